// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the M stage and the data memory responder.
// The pipeline side drives the request fields; the responder drives the
// read data, the stall back-pressure and the fault pulse.
interface data_mem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [3:0]  ByteEnM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        stall;
    logic        MemFault;

    modport master (
        output MemReadM, MemWriteM, ByteEnM, AddrM, WriteDataM,
        input  ReadDataM, stall, MemFault
    );

    modport slave (
        input  MemReadM, MemWriteM, ByteEnM, AddrM, WriteDataM,
        output ReadDataM, stall, MemFault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-stage responder: a word-organised data RAM with per-byte write lanes
// that takes LATENCY wait cycles per access and freezes the pipeline via
// stall until the access completes. Bad requests raise a one-cycle MemFault
// instead of touching the RAM.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // First byte address past the end of the RAM; 33 bits so the compare
    // cannot overflow for the largest legal depth.
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   readData;
    logic          faultPulse;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          accessEdge;
    logic          outOfRange;
    logic          noLanes;
    logic          misaligned;
    logic          conflict;
    logic          fault;
    logic          doLoad;
    logic          doStore;
    logic [AW-1:0] wordIdx;

    // Decode the request and classify it; the access itself happens on the
    // edge that moves WAIT to DONE, using whatever inputs are present then.
    always_comb begin
        req        = bus.MemReadM | bus.MemWriteM;
        wordIdx    = bus.AddrM[AW+1:2];
        outOfRange = ({1'b0, bus.AddrM} >= BYTE_LIMIT);
        noLanes    = (bus.ByteEnM == 4'b0000);
        misaligned = (bus.ByteEnM == 4'b1111) && (bus.AddrM[1:0] != 2'b00);
        conflict   = bus.MemReadM & bus.MemWriteM;
        fault      = outOfRange | noLanes | misaligned | conflict;
        accessEdge = reset && (state == WAIT) && (cnt == 4'd0);
        doLoad     = accessEdge & ~fault & bus.MemReadM & ~bus.MemWriteM;
        doStore    = accessEdge & ~fault & bus.MemWriteM & ~bus.MemReadM;
    end

    // Access sequencer: accept in IDLE, count down the wait cycles, spend
    // one cycle in DONE so the pipeline can advance, then return to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Response registers: load data is captured at the access edge and held
    // until the next completed load; a fault zeroes it and pulses MemFault
    // for exactly the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            readData   <= 32'd0;
            faultPulse <= 1'b0;
        end else begin
            faultPulse <= accessEdge & fault;
            if (accessEdge & fault) begin
                readData <= 32'd0;
            end else if (doLoad) begin
                readData <= mem[wordIdx];
            end
        end
    end

    // RAM array with independent byte lanes; deliberately not reset so the
    // contents survive a pipeline reset, and a store aborted by reset never
    // reaches this block.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (doStore && bus.ByteEnM[i]) begin
                mem[wordIdx][8*i +: 8] <= bus.WriteDataM[8*i +: 8];
            end
        end
    end

    // Back-pressure is combinational so the requester sees it in the same
    // cycle the request first appears.
    assign bus.stall     = req & (state != DONE);
    assign bus.ReadDataM = readData;
    assign bus.MemFault  = faultPulse;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a
// randomized run, all checked against a word-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk;
    logic reset;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] modelMem   [DEPTH];
    bit          modelKnown [DEPTH];
    logic [31:0] lastRead;

    int          nStall;
    logic [31:0] rdata;
    logic        fault;
    bit          early;
    bit          tmo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fault rules evaluated directly from the address/lane rules.
    function automatic bit model_fault(bit rd, bit wr, logic [3:0] be, logic [31:0] addr);
        return (longint'(addr) >= longint'(DEPTH) * 4) || (be == 4'h0) ||
               (be == 4'hF && (addr % 4) != 0) || (rd && wr);
    endfunction

    // Reference model: byte-lane store into the word array.
    function automatic void model_store(logic [31:0] addr, logic [3:0] be, logic [31:0] data);
        int idx = int'(addr / 4);
        for (int i = 0; i < 4; i++)
            if (be[i]) modelMem[idx][8*i +: 8] = data[8*i +: 8];
        if (be == 4'hF) modelKnown[idx] = 1'b1;
    endfunction

    // Drive one request in an IDLE cycle and follow it until stall drops.
    task automatic do_access(input bit rd, input bit wr, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int ns, output logic [31:0] rd_o, output logic f_o,
                             output bit early_o, output bit tmo_o);
        @(negedge clk);
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.ByteEnM    = be;
        bus.AddrM      = addr;
        bus.WriteDataM = data;
        ns = 0; early_o = 1'b0; tmo_o = 1'b0;
        #1;
        while (bus.stall === 1'b1 && ns < 40) begin
            if (bus.MemFault !== 1'b0) early_o = 1'b1;
            ns++;
            @(negedge clk);
            #1;
        end
        if (bus.stall !== 1'b0) tmo_o = 1'b1;
        rd_o = bus.ReadDataM;
        f_o  = bus.MemFault;
    endtask

    // Drop the request at the start of the cycle after DONE.
    task automatic release_bus();
        @(negedge clk);
        bus.MemReadM   = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ByteEnM    = 4'h0;
        bus.AddrM      = 32'h0;
        bus.WriteDataM = 32'h0;
    endtask

    task automatic test_reset();
        release_bus();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lastRead = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall);
        end
        checks++;
        if (bus.ReadDataM !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.ReadDataM);
        end
        checks++;
        if (bus.MemFault !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_fault: got %b expected 0", bus.MemFault);
        end
    endtask

    task automatic test_store_load();
        do_access(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, nStall, rdata, fault, early, tmo);
        model_store(32'h10, 4'hF, 32'hDEADBEEF);
        checks++;
        if (tmo || nStall != LAT + 1) begin
            errors++; $display("[TB] FAIL store_stall_cycles: got %0d expected %0d", nStall, LAT + 1);
        end
        checks++;
        if (fault !== 1'b0 || rdata !== lastRead) begin
            errors++; $display("[TB] FAIL store_resp: got fault=%b rdata=%h expected 0/%h", fault, rdata, lastRead);
        end
        release_bus();
        do_access(1, 0, 4'hF, 32'h10, 32'h0, nStall, rdata, fault, early, tmo);
        checks++;
        if (tmo || nStall != LAT + 1) begin
            errors++; $display("[TB] FAIL load_stall_cycles: got %0d expected %0d", nStall, LAT + 1);
        end
        checks++;
        if (rdata !== modelMem[4] || fault !== 1'b0) begin
            errors++; $display("[TB] FAIL load_full_word: got %h expected %h", rdata, modelMem[4]);
        end
        lastRead = modelMem[4];
        release_bus();
    endtask

    task automatic test_byte_lane();
        do_access(0, 1, 4'b0010, 32'h10, 32'h0000AA00, nStall, rdata, fault, early, tmo);
        model_store(32'h10, 4'b0010, 32'h0000AA00);
        release_bus();
        do_access(1, 0, 4'hF, 32'h10, 32'h0, nStall, rdata, fault, early, tmo);
        checks++;
        if (rdata !== 32'hDEADAAEF || rdata !== modelMem[4]) begin
            errors++; $display("[TB] FAIL byte_lane_merge: got %h expected DEADAAEF", rdata);
        end
        lastRead = rdata;
        release_bus();
    endtask

    task automatic test_faults();
        do_access(1, 0, 4'hF, 32'h1000, 32'h0, nStall, rdata, fault, early, tmo);
        checks++;
        if (tmo || early || fault !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL oob_load: got fault=%b rdata=%h early=%b expected 1/00000000/0", fault, rdata, early);
        end
        lastRead = 32'h0;
        release_bus();
        #1;
        checks++;
        if (bus.MemFault !== 1'b0) begin
            errors++; $display("[TB] FAIL fault_pulse_width: got %b expected 0", bus.MemFault);
        end
        do_access(0, 1, 4'hF, 32'h12, 32'h55555555, nStall, rdata, fault, early, tmo);
        checks++;
        if (fault !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL misaligned_store: got fault=%b rdata=%h expected 1/00000000", fault, rdata);
        end
        release_bus();
        do_access(1, 0, 4'hF, 32'h10, 32'h0, nStall, rdata, fault, early, tmo);
        checks++;
        if (rdata !== modelMem[4] || fault !== 1'b0) begin
            errors++; $display("[TB] FAIL ram_untouched: got %h expected %h", rdata, modelMem[4]);
        end
        lastRead = rdata;
        release_bus();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pattern;
        int         pos;
        do_access(0, 1, 4'hF, 32'h14, 32'hCAFEF00D, nStall, rdata, fault, early, tmo);
        model_store(32'h14, 4'hF, 32'hCAFEF00D);
        release_bus();
        pattern = 8'h0;
        pos = 7;
        do_access(1, 0, 4'hF, 32'h10, 32'h0, nStall, rdata, fault, early, tmo);
        for (int i = 0; i < nStall && pos >= 0; i++) begin pattern[pos] = 1'b1; pos--; end
        pos--;
        checks++;
        if (rdata !== modelMem[4]) begin
            errors++; $display("[TB] FAIL b2b_first_data: got %h expected %h", rdata, modelMem[4]);
        end
        do_access(1, 0, 4'hF, 32'h14, 32'h0, nStall, rdata, fault, early, tmo);
        for (int i = 0; i < nStall && pos >= 0; i++) begin pattern[pos] = 1'b1; pos--; end
        checks++;
        if (rdata !== modelMem[5]) begin
            errors++; $display("[TB] FAIL b2b_second_data: got %h expected %h", rdata, modelMem[5]);
        end
        checks++;
        if (pattern !== 8'b1110_1110) begin
            errors++; $display("[TB] FAIL b2b_stall_pattern: got %b expected 11101110", pattern);
        end
        lastRead = rdata;
        release_bus();
    endtask

    task automatic test_reset_abort();
        do_access(0, 1, 4'hF, 32'h20, 32'h11112222, nStall, rdata, fault, early, tmo);
        model_store(32'h20, 4'hF, 32'h11112222);
        release_bus();
        bus.MemWriteM  = 1'b1;
        bus.ByteEnM    = 4'hF;
        bus.AddrM      = 32'h20;
        bus.WriteDataM = 32'h12345678;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.MemWriteM = 1'b0;
        lastRead = 32'h0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.ReadDataM !== 32'h0 || bus.MemFault !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_outputs: got stall=%b rdata=%h fault=%b expected 0/00000000/0",
                               bus.stall, bus.ReadDataM, bus.MemFault);
        end
        do_access(1, 0, 4'hF, 32'h20, 32'h0, nStall, rdata, fault, early, tmo);
        checks++;
        if (tmo || nStall != LAT + 1) begin
            errors++; $display("[TB] FAIL abort_idle_after: got %0d stall cycles expected %0d", nStall, LAT + 1);
        end
        checks++;
        if (rdata !== modelMem[8]) begin
            errors++; $display("[TB] FAIL abort_not_committed: got %h expected %h", rdata, modelMem[8]);
        end
        lastRead = rdata;
        release_bus();
    endtask

    task automatic test_random();
        bit          rd, wr, expF;
        logic [3:0]  be;
        logic [31:0] addr, data, expD;
        int          sel;
        for (int w = 0; w < 16; w++) begin
            data = $urandom;
            do_access(0, 1, 4'hF, 32'(w * 4), data, nStall, rdata, fault, early, tmo);
            model_store(32'(w * 4), 4'hF, data);
            release_bus();
        end
        for (int n = 0; n < 80; n++) begin
            sel  = int'($urandom_range(0, 19));
            rd   = (sel < 9) || (sel >= 18);
            wr   = (sel >= 9);
            be   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            addr = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63));
            data = $urandom;
            expF = model_fault(rd, wr, be, addr);
            do_access(rd, wr, be, addr, data, nStall, rdata, fault, early, tmo);
            if (expF)       expD = 32'h0;
            else if (rd)    expD = modelMem[int'(addr / 4)];
            else            expD = lastRead;
            if (!expF && wr) model_store(addr, be, data);
            checks++;
            if (tmo || early || nStall != LAT + 1) begin
                errors++; $display("[TB] FAIL rand_timing[%0d]: got %0d stall cycles early=%b expected %0d", n, nStall, early, LAT + 1);
            end
            checks++;
            if (fault !== expF || rdata !== expD) begin
                errors++; $display("[TB] FAIL rand_resp[%0d] rd=%b wr=%b be=%h addr=%h: got fault=%b rdata=%h expected %b/%h",
                                   n, rd, wr, be, addr, fault, rdata, expF, expD);
            end
            lastRead = expD;
            if ($urandom_range(0, 1) == 0) release_bus();
        end
        release_bus();
    endtask

    initial begin
        reset = 1'b0;
        lastRead = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin modelMem[i] = 32'h0; modelKnown[i] = 1'b0; end
        test_reset();
        test_store_load();
        test_byte_lane();
        test_faults();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
